secuenciador_calculadora: RTL and testbench
===========================================

// Module: secuenciador_calculadora
// PURPOSE
//  Keystroke sequencer for the 8-digit calculator front end. Accepts debounced key strobes,
//  enforces entry order (sign, 3 digits, operator, 3 digits, '='), and drives pulsacion/tipo/CSseg
//  into the display scanner. Packs operands as BCD, runs a start/done handshake with the
//  add/subtract unit, and holds CSseg = segeq while the result is shown.
// PARAMETERS
//  TIMEOUT_CYC  1023  max clk cycles between alu_start and alu_done before the error state
//  TW           10    width of timeout counter; TW >= clog2(TIMEOUT_CYC+1)
// PORTS
//  clk          in   1   single system clock; all state updates on posedge clk
//  rst_n        in   1   synchronous reset, active-low; sampled on posedge clk
//  key_valid    in   1   1-cycle strobe: key_code valid
//  key_code     in   4   0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear, 14-15 unused
//  alu_done     in   1   1-cycle strobe from arithmetic unit: result ready
//  pulsacion    out  4   entry slot of last accepted key (0 none, 1..8)
//  tipo         out  1   1 = last accepted key is a digit, 0 = sign/operator
//  CSseg        out  7   7-seg code of last accepted key (active-low, bit6=a..bit0=g)
//  key_stb      out  1   1-cycle strobe: pulsacion/tipo/CSseg updated this cycle
//  num1_bcd     out  12  operand 1, BCD {hundreds,tens,units}
//  num2_bcd     out  12  operand 2, BCD
//  signo1       out  1   1 = operand 1 negative
//  op_resta     out  1   1 = operator '-', 0 = '+'
//  alu_start    out  1   1-cycle strobe: operands stable, begin computation
//  busy         out  1   high in CALC
//  err          out  1   high in ERR (illegal key or ALU timeout)
// BEHAVIOUR
//  Reset: pulsacion=0, tipo=0, CSseg=7'b1111111, key_stb=0, num1_bcd=num2_bcd=0, signo1=0,
//   op_resta=0, alu_start=0, busy=0, err=0, state=S_SIGN, timeout counter=0.
//  FSM states: S_SIGN, S_NUM1, S_OP, S_NUM2, S_EQ, S_CALC, S_SHOW, S_ERR.
//  S_SIGN: '+'/'-' -> signo1, pulsacion=1, tipo=0, CSseg=segplus/segmin, -> S_NUM1.
//  S_NUM1: digit shifts into num1_bcd (left shift 4, new digit in units), pulsacion 2..4, tipo=1;
//   after pulsacion 4 -> S_OP.
//  S_OP: '+'/'-' -> op_resta, pulsacion=5, tipo=0 -> S_NUM2.
//  S_NUM2: as S_NUM1 into num2_bcd, pulsacion 6..8; after 8 -> S_EQ.
//  S_EQ: '=' -> CSseg=segeq, key_stb, alu_start=1 for exactly 1 cycle -> S_CALC (pulsacion stays 8).
//  S_CALC: busy=1; alu_done -> S_SHOW; timeout counter reaches TIMEOUT_CYC -> S_ERR.
//  S_SHOW: CSseg held at segeq; any non-clear key ignored.
//  S_ERR: err=1, CSseg=segmin; only clear leaves.
//  Illegal key for the current state (digit in S_SIGN/S_OP/S_EQ, sign/operator in NUM states,
//   '=' before S_EQ, codes 14-15): -> S_ERR, no key_stb, operands unchanged.
//  Clear (13): from any state, next cycle all outputs and state return to reset values.
//   Clear during S_CALC aborts; a later alu_done is ignored and alu_start is not re-issued.
//  key_valid and alu_done in the same S_CALC cycle: alu_done wins, key is dropped.
//  key_stb asserts in the same cycle the registered outputs change (1-cycle key-to-display latency).
//  All outputs are registered. alu_done outside S_CALC is ignored.
//  Digit encodings: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100,
//   6=0100000, 7=0001111, 8=0000000, 9=0000100.
// STRUCTURE
//  Shared package calc_pkg: key codes (KEY_PLUS=10, KEY_MINUS=11, KEY_EQ=12, KEY_CLR=13),
//   seg constants nul/segmin/segeq/segplus, and FSM state encodings.
//  One sub-module: bcd_a_7seg (4-bit digit -> 7-bit active-low code, combinational).
//  Timeout counter is inline.
// TESTING
//  Reset: hold rst_n=0 for 2 clk -> CSseg=1111111, pulsacion=0, alu_start=0, err=0.
//  Keys '-',1,2,3,'+',4,5,6,'=' -> num1_bcd=12'h123, signo1=1, num2_bcd=12'h456, op_resta=0;
//   pulsacion steps 1..8; exactly one alu_start pulse; CSseg=1110110.
//  Digit 7 as first key -> err=1, CSseg=1111110, no key_stb; then clear -> reset values.
//  '=' accepted, no alu_done for 1023 cycles -> err=1 at that count; later alu_done -> no change.
//  Clear during S_CALC, then alu_done -> state S_SIGN, busy=0, no further alu_start.
//  key_valid and alu_done in the same S_CALC cycle -> S_SHOW, key ignored, CSseg stays 1110110.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator keystroke sequencer: key codes,
// 7-segment glyphs (active-low, bit6=a .. bit0=g) and FSM state encoding.
package calc_pkg;

   localparam logic [3:0] KEY_PLUS  = 4'd10;
   localparam logic [3:0] KEY_MINUS = 4'd11;
   localparam logic [3:0] KEY_EQ    = 4'd12;
   localparam logic [3:0] KEY_CLR   = 4'd13;

   localparam logic [6:0] SEG_NUL  = 7'b1111111;
   localparam logic [6:0] SEG_MIN  = 7'b1111110;
   localparam logic [6:0] SEG_EQ   = 7'b1110110;
   localparam logic [6:0] SEG_PLUS = 7'b1001110;

   typedef enum logic [2:0] {
      S_SIGN = 3'd0,
      S_NUM1 = 3'd1,
      S_OP   = 3'd2,
      S_NUM2 = 3'd3,
      S_EQ   = 3'd4,
      S_CALC = 3'd5,
      S_SHOW = 3'd6,
      S_ERR  = 3'd7
   } estado_t;

   function automatic logic es_digito(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic es_signo(input logic [3:0] k);
      return (k == KEY_PLUS) || (k == KEY_MINUS);
   endfunction

endpackage

// File: rtl/secuenciador_calculadora_if.sv
// Key, ALU-handshake and display bundle between the sequencer and its neighbours.
interface secuenciador_calculadora_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        alu_done;
   logic [3:0]  pulsacion;
   logic        tipo;
   logic [6:0]  CSseg;
   logic        key_stb;
   logic [11:0] num1_bcd;
   logic [11:0] num2_bcd;
   logic        signo1;
   logic        op_resta;
   logic        alu_start;
   logic        busy;
   logic        err;

   modport slave (
      input  key_valid, key_code, alu_done,
      output pulsacion, tipo, CSseg, key_stb, num1_bcd, num2_bcd,
             signo1, op_resta, alu_start, busy, err
   );

   modport master (
      output key_valid, key_code, alu_done,
      input  pulsacion, tipo, CSseg, key_stb, num1_bcd, num2_bcd,
             signo1, op_resta, alu_start, busy, err
   );
endinterface

// File: rtl/bcd_a_7seg.sv
// BCD digit to active-low 7-segment code; non-digit codes show a blank glyph.
module bcd_a_7seg
   import calc_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Glyph lookup
   always_comb begin
      o_seg = SEG_NUL;
      case (i_bcd)
         4'd0:    o_seg = 7'b0000001;
         4'd1:    o_seg = 7'b1001111;
         4'd2:    o_seg = 7'b0010010;
         4'd3:    o_seg = 7'b0000110;
         4'd4:    o_seg = 7'b1001100;
         4'd5:    o_seg = 7'b0100100;
         4'd6:    o_seg = 7'b0100000;
         4'd7:    o_seg = 7'b0001111;
         4'd8:    o_seg = 7'b0000000;
         4'd9:    o_seg = 7'b0000100;
         default: o_seg = SEG_NUL;
      endcase
   end

endmodule

// File: rtl/secuenciador_calculadora.sv
// Keystroke sequencer: enforces sign/3 digits/op/3 digits/'=' entry order,
// packs BCD operands and runs the start/done handshake with the ALU.
module secuenciador_calculadora
   import calc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023,
   parameter int TW          = 10
)(
   input  logic                      clk,
   input  logic                      rst_n,
   secuenciador_calculadora_if.slave bus
);

   localparam logic [TW-1:0] CNT_FIN = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] CNT_UNO = TW'(1);

   estado_t       r_state, w_state_n;
   logic [3:0]    r_pul, w_pul_n;
   logic          r_tipo, w_tipo_n;
   logic [6:0]    r_seg, w_seg_n;
   logic          r_stb, w_stb_n;
   logic [11:0]   r_num1, w_num1_n;
   logic [11:0]   r_num2, w_num2_n;
   logic          r_signo, w_signo_n;
   logic          r_op, w_op_n;
   logic          r_start, w_start_n;
   logic          r_busy, r_err;
   logic [TW-1:0] r_cnt, w_cnt_n;
   logic [6:0]    w_dig_seg;
   logic          w_clr, w_dig, w_sgn, w_menos;

   bcd_a_7seg u_bcd_a_7seg (
      .i_bcd (bus.key_code),
      .o_seg (w_dig_seg)
   );

   assign w_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
   assign w_dig   = bus.key_valid && es_digito(bus.key_code);
   assign w_sgn   = bus.key_valid && es_signo(bus.key_code);
   assign w_menos = (bus.key_code == KEY_MINUS);

   // Next-state and next-output decode
   always_comb begin
      w_state_n = r_state;
      w_pul_n   = r_pul;
      w_tipo_n  = r_tipo;
      w_seg_n   = r_seg;
      w_stb_n   = 1'b0;
      w_num1_n  = r_num1;
      w_num2_n  = r_num2;
      w_signo_n = r_signo;
      w_op_n    = r_op;
      w_start_n = 1'b0;
      w_cnt_n   = r_cnt;
      if (w_clr) begin
         // Clear wins everywhere, including over a coincident alu_done.
         w_state_n = S_SIGN;
         w_pul_n   = 4'd0;
         w_tipo_n  = 1'b0;
         w_seg_n   = SEG_NUL;
         w_num1_n  = 12'd0;
         w_num2_n  = 12'd0;
         w_signo_n = 1'b0;
         w_op_n    = 1'b0;
         w_cnt_n   = {TW{1'b0}};
      end else begin
         case (r_state)
            S_SIGN, S_OP: begin
               if (w_sgn) begin
                  w_pul_n  = (r_state == S_SIGN) ? 4'd1 : 4'd5;
                  w_tipo_n = 1'b0;
                  w_seg_n  = w_menos ? SEG_MIN : SEG_PLUS;
                  w_stb_n  = 1'b1;
                  if (r_state == S_SIGN) begin
                     w_signo_n = w_menos;
                     w_state_n = S_NUM1;
                  end else begin
                     w_op_n    = w_menos;
                     w_state_n = S_NUM2;
                  end
               end else if (bus.key_valid) begin
                  w_state_n = S_ERR;
               end else begin
                  w_state_n = r_state;
               end
            end
            S_NUM1, S_NUM2: begin
               if (w_dig) begin
                  w_pul_n  = r_pul + 4'd1;
                  w_tipo_n = 1'b1;
                  w_seg_n  = w_dig_seg;
                  w_stb_n  = 1'b1;
                  if (r_state == S_NUM1) begin
                     w_num1_n  = {r_num1[7:0], bus.key_code};
                     w_state_n = (r_pul == 4'd3) ? S_OP : S_NUM1;
                  end else begin
                     w_num2_n  = {r_num2[7:0], bus.key_code};
                     w_state_n = (r_pul == 4'd7) ? S_EQ : S_NUM2;
                  end
               end else if (bus.key_valid) begin
                  w_state_n = S_ERR;
               end else begin
                  w_state_n = r_state;
               end
            end
            S_EQ: begin
               if (bus.key_valid && (bus.key_code == KEY_EQ)) begin
                  w_seg_n   = SEG_EQ;
                  w_stb_n   = 1'b1;
                  w_start_n = 1'b1;
                  w_cnt_n   = {TW{1'b0}};
                  w_state_n = S_CALC;
               end else if (bus.key_valid) begin
                  w_state_n = S_ERR;
               end else begin
                  w_state_n = S_EQ;
               end
            end
            S_CALC: begin
               // Keys other than clear are dropped while the ALU works.
               if (bus.alu_done) begin
                  w_state_n = S_SHOW;
               end else if (r_cnt == CNT_FIN) begin
                  w_state_n = S_ERR;
               end else begin
                  w_cnt_n = r_cnt + CNT_UNO;
               end
            end
            S_SHOW:  w_state_n = S_SHOW;
            S_ERR:   w_state_n = S_ERR;
            default: w_state_n = S_ERR;
         endcase
      end
      if (w_state_n == S_ERR) begin
         w_seg_n = SEG_MIN;
      end else begin
         w_seg_n = w_seg_n;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_SIGN;
         r_pul   <= 4'd0;
         r_tipo  <= 1'b0;
         r_seg   <= SEG_NUL;
         r_stb   <= 1'b0;
         r_num1  <= 12'd0;
         r_num2  <= 12'd0;
         r_signo <= 1'b0;
         r_op    <= 1'b0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= {TW{1'b0}};
      end else begin
         r_state <= w_state_n;
         r_pul   <= w_pul_n;
         r_tipo  <= w_tipo_n;
         r_seg   <= w_seg_n;
         r_stb   <= w_stb_n;
         r_num1  <= w_num1_n;
         r_num2  <= w_num2_n;
         r_signo <= w_signo_n;
         r_op    <= w_op_n;
         r_start <= w_start_n;
         r_busy  <= (w_state_n == S_CALC);
         r_err   <= (w_state_n == S_ERR);
         r_cnt   <= w_cnt_n;
      end
   end

   assign bus.pulsacion = r_pul;
   assign bus.tipo      = r_tipo;
   assign bus.CSseg     = r_seg;
   assign bus.key_stb   = r_stb;
   assign bus.num1_bcd  = r_num1;
   assign bus.num2_bcd  = r_num2;
   assign bus.signo1    = r_signo;
   assign bus.op_resta  = r_op;
   assign bus.alu_start = r_start;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_secuenciador_calculadora.sv
// Bench for secuenciador_calculadora: table-driven entry sequence, directed corner
// cases and random keystrokes against a grammar-level reference model.
module tb_secuenciador_calculadora;

   localparam int TO = 1023;
   localparam logic [6:0] G_NUL  = 7'b1111111;
   localparam logic [6:0] G_MIN  = 7'b1111110;
   localparam logic [6:0] G_EQ   = 7'b1110110;
   localparam logic [6:0] G_PLUS = 7'b1001110;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   secuenciador_calculadora_if bus ();

   secuenciador_calculadora #(.TIMEOUT_CYC(TO), .TW(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] seg_dig [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;

   // Reference model: n = keys accepted so far in the entry grammar
   int         m_n, m_wait, m_num1, m_num2;
   bit         m_calc, m_show, m_err, m_tipo, m_stb, m_signo, m_op, m_start;
   logic [3:0] m_pul;
   logic [6:0] m_seg;

   typedef struct {
      logic [3:0] code;
      logic [3:0] pul;
      logic       tipo;
      logic [6:0] seg;
      logic       start;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_wait = 0; m_num1 = 0; m_num2 = 0;
      m_calc = 0; m_show = 0; m_err = 0; m_tipo = 0; m_stb = 0;
      m_signo = 0; m_op = 0; m_start = 0; m_pul = 4'd0; m_seg = G_NUL;
   endtask

   function automatic bit legal(input int n, input logic [3:0] c);
      if (n == 0 || n == 4) return (c == 4'd10 || c == 4'd11);
      else if (n == 8)      return (c == 4'd12);
      else                  return (c <= 4'd9);
   endfunction

   task automatic model_step(input bit kv, input logic [3:0] c, input bit done);
      m_stb = 0; m_start = 0;
      if (kv && c == 4'd13) begin
         model_reset();
      end else if (m_err || m_show) begin
         m_stb = 0;
      end else if (m_calc) begin
         if (done) begin
            m_calc = 0; m_show = 1;
         end else begin
            m_wait++;
            if (m_wait == TO) begin
               m_calc = 0; m_err = 1; m_seg = G_MIN;
            end
         end
      end else if (kv) begin
         if (legal(m_n, c)) begin
            m_stb = 1;
            if (m_n == 8) begin
               m_seg = G_EQ; m_start = 1; m_calc = 1; m_wait = 0;
            end else begin
               m_n++;
               m_pul = 4'(m_n);
               if (c <= 4'd9) begin
                  m_tipo = 1; m_seg = seg_dig[c];
                  if (m_n <= 4) m_num1 = m_num1 * 16 + int'(c);
                  else          m_num2 = m_num2 * 16 + int'(c);
               end else begin
                  m_tipo = 0; m_seg = (c == 4'd11) ? G_MIN : G_PLUS;
                  if (m_n == 1) m_signo = (c == 4'd11);
                  else          m_op    = (c == 4'd11);
               end
            end
         end else begin
            m_err = 1; m_seg = G_MIN;
         end
      end
   endtask

   function automatic logic [41:0] dut_vec();
      return {bus.pulsacion, bus.tipo, bus.CSseg, bus.key_stb, bus.num1_bcd, bus.num2_bcd,
              bus.signo1, bus.op_resta, bus.alu_start, bus.busy, bus.err};
   endfunction

   function automatic logic [41:0] mod_vec();
      logic [11:0] a, b;
      a = m_num1[11:0];
      b = m_num2[11:0];
      return {m_pul, m_tipo, m_seg, m_stb, a, b, m_signo, m_op, m_start, m_calc, m_err};
   endfunction

   task automatic cycle(input bit kv, input logic [3:0] c, input bit done, input string name);
      bus.key_valid = kv; bus.key_code = c; bus.alu_done = done;
      model_step(kv, c, done);
      @(posedge clk); #1;
      if (bus.alu_start) n_start++;
      chk(name, 64'(dut_vec()), 64'(mod_vec()));
   endtask

   task automatic play_seq();
      for (int i = 0; i < 9; i++) cycle(1'b1, tbl[i].code, 1'b0, "seq_vec");
   endtask

   initial begin
      bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.alu_done = 1'b0;
      tbl[0] = '{4'd11, 4'd1, 1'b0, G_MIN,         1'b0};
      tbl[1] = '{4'd1,  4'd2, 1'b1, 7'b1001111,    1'b0};
      tbl[2] = '{4'd2,  4'd3, 1'b1, 7'b0010010,    1'b0};
      tbl[3] = '{4'd3,  4'd4, 1'b1, 7'b0000110,    1'b0};
      tbl[4] = '{4'd10, 4'd5, 1'b0, G_PLUS,        1'b0};
      tbl[5] = '{4'd4,  4'd6, 1'b1, 7'b1001100,    1'b0};
      tbl[6] = '{4'd5,  4'd7, 1'b1, 7'b0100100,    1'b0};
      tbl[7] = '{4'd6,  4'd8, 1'b1, 7'b0100000,    1'b0};
      tbl[8] = '{4'd12, 4'd8, 1'b1, G_EQ,          1'b1};

      // Reset
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_seg", bus.CSseg, G_NUL);
      chk("rst_pul", bus.pulsacion, 4'd0);
      chk("rst_start", bus.alu_start, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_vec", 64'(dut_vec()), 64'(mod_vec()));
      rst_n = 1'b1;

      // Table-driven main entry sequence
      n_start = 0;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, tbl[i].code, 1'b0, "tbl_vec");
         chk("tbl_pul", bus.pulsacion, tbl[i].pul);
         chk("tbl_seg", bus.CSseg, tbl[i].seg);
         chk("tbl_stb", bus.key_stb, 1'b1);
         chk("tbl_start", bus.alu_start, tbl[i].start);
         if (i < 8) chk("tbl_tipo", bus.tipo, tbl[i].tipo);
      end
      chk("num1", bus.num1_bcd, 12'h123);
      chk("num2", bus.num2_bcd, 12'h456);
      chk("signo1", bus.signo1, 1'b1);
      chk("op_resta", bus.op_resta, 1'b0);
      chk("busy_calc", bus.busy, 1'b1);

      // ALU timeout: err rises exactly 1023 cycles after the start pulse
      for (int i = 1; i < TO; i++) cycle(1'b0, 4'd0, 1'b0, "calc_wait");
      chk("no_early_timeout", bus.err, 1'b0);
      chk("start_once", n_start, 1);
      cycle(1'b0, 4'd0, 1'b0, "timeout");
      chk("timeout_err", bus.err, 1'b1);
      chk("timeout_seg", bus.CSseg, G_MIN);
      cycle(1'b0, 4'd0, 1'b1, "late_done");
      chk("late_done_err", bus.err, 1'b1);
      chk("late_done_busy", bus.busy, 1'b0);
      cycle(1'b1, 4'd13, 1'b0, "clr_after_err");
      chk("clr_seg", bus.CSseg, G_NUL);

      // Clear during CALC aborts; later alu_done ignored
      n_start = 0;
      play_seq();
      repeat (5) cycle(1'b0, 4'd0, 1'b0, "calc_idle");
      cycle(1'b1, 4'd13, 1'b0, "clr_in_calc");
      cycle(1'b0, 4'd0, 1'b1, "done_after_clr");
      repeat (3) cycle(1'b0, 4'd0, 1'b0, "idle_after_clr");
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_pul", bus.pulsacion, 4'd0);
      chk("abort_start_once", n_start, 1);
      cycle(1'b1, 4'd10, 1'b0, "sign_after_abort");
      chk("sign_after_abort_pul", bus.pulsacion, 4'd1);
      cycle(1'b1, 4'd13, 1'b0, "clr");

      // Key and alu_done together in CALC: done wins
      play_seq();
      repeat (2) cycle(1'b0, 4'd0, 1'b0, "calc_idle");
      cycle(1'b1, 4'd5, 1'b1, "key_and_done");
      chk("kd_seg", bus.CSseg, G_EQ);
      chk("kd_stb", bus.key_stb, 1'b0);
      chk("kd_busy", bus.busy, 1'b0);
      cycle(1'b1, 4'd3, 1'b0, "show_key");
      chk("show_seg", bus.CSseg, G_EQ);
      chk("show_pul", bus.pulsacion, 4'd8);
      cycle(1'b1, 4'd13, 1'b0, "clr");

      // Illegal first key, then clear
      cycle(1'b1, 4'd7, 1'b0, "digit_first");
      chk("digit_first_err", bus.err, 1'b1);
      chk("digit_first_seg", bus.CSseg, G_MIN);
      chk("digit_first_stb", bus.key_stb, 1'b0);
      cycle(1'b1, 4'd13, 1'b0, "clr_from_err");
      chk("clr_err", bus.err, 1'b0);
      chk("clr_seg2", bus.CSseg, G_NUL);

      // Unused code inside operand 1 keeps the operand
      cycle(1'b1, 4'd10, 1'b0, "plus");
      cycle(1'b1, 4'd2, 1'b0, "dig2");
      cycle(1'b1, 4'd14, 1'b0, "code14");
      chk("code14_err", bus.err, 1'b1);
      chk("code14_num1", bus.num1_bcd, 12'h002);
      cycle(1'b1, 4'd13, 1'b0, "clr");

      // Random keystrokes against the model
      for (int k = 0; k < 4000; k++) begin
         int r;
         logic [3:0] c;
         bit kv, dn;
         r  = int'($urandom_range(0, 99));
         kv = 1'b1;
         if (r < 3)       c = 4'd13;
         else if (r < 60) begin
            if (m_n == 0 || m_n == 4) c = 4'($urandom_range(10, 11));
            else if (m_n == 8)        c = 4'd12;
            else                      c = 4'($urandom_range(0, 9));
         end
         else if (r < 68) c = 4'($urandom_range(0, 15));
         else begin
            c = 4'd0; kv = 1'b0;
         end
         dn = ($urandom_range(0, 99) < 8);
         cycle(kv, c, dn, "rand_vec");
      end

      bus.key_valid = 1'b0; bus.alu_done = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
